// File: rtl/seq_controller.sv
`default_nettype none
// ============================================================================
// Module   : seq_controller
// Brief    : Instruction-sequencing FSM for a simple accumulator CPU, with
//            memory-ready stalls, halt/resume and a retired-instruction count.
// Revision : 1.0
// ============================================================================
module seq_controller #(
    parameter int OPW   = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             zero,
    input  logic [OPW-1:0]   opcode,
    input  logic             mem_ready,
    input  logic             resume,
    output logic             sel,
    output logic             rd,
    output logic             ld_ir,
    output logic             halt,
    output logic             inc_pc,
    output logic             ld_ac,
    output logic             ld_pc,
    output logic             wr,
    output logic             data_e,
    output logic [3:0]       phase,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_INST_ADDR  = 4'd0,
        S_INST_FETCH = 4'd1,
        S_INST_LOAD  = 4'd2,
        S_IDLE       = 4'd3,
        S_OP_ADDR    = 4'd4,
        S_OP_FETCH   = 4'd5,
        S_ALU_OP     = 4'd6,
        S_STORE      = 4'd7,
        S_HALTED     = 4'd8
    } state_t;

    state_t           r_state;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;

    logic       w_hi_nz;
    logic [2:0] w_op3;
    logic       w_hlt, w_skz, w_jmp, w_sto, w_alu;

    // Opcode bits above [2:0] only exist when OPW > 3; any nonzero value there is illegal.
    generate
        if (OPW > 3) begin : g_ext_opcode
            assign w_hi_nz = |opcode[OPW-1:3];
        end else begin : g_base_opcode
            assign w_hi_nz = 1'b0;
        end
    endgenerate

    assign w_op3 = opcode[2:0];
    assign w_hlt = w_hi_nz | (w_op3 == 3'b000);
    assign w_skz = ~w_hi_nz & (w_op3 == 3'b001);
    assign w_sto = ~w_hi_nz & (w_op3 == 3'b110);
    assign w_jmp = ~w_hi_nz & (w_op3 == 3'b111);
    assign w_alu = ~w_hi_nz & (w_op3 >= 3'b010) & (w_op3 <= 3'b101);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_INST_ADDR;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_INST_ADDR:  r_state <= S_INST_FETCH;
                S_INST_FETCH: if (mem_ready) r_state <= S_INST_LOAD;
                S_INST_LOAD:  r_state <= S_IDLE;
                S_IDLE:       r_state <= S_OP_ADDR;
                S_OP_ADDR: begin
                    if (w_hlt) begin
                        r_state <= S_HALTED;
                        if (w_hi_nz) r_illegal <= 1'b1;
                    end else begin
                        r_state <= S_OP_FETCH;
                    end
                end
                S_OP_FETCH:   if (!w_alu || mem_ready) r_state <= S_ALU_OP;
                S_ALU_OP:     r_state <= S_STORE;
                S_STORE: begin
                    if (!w_sto || mem_ready) begin
                        r_state <= S_INST_ADDR;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_HALTED:     if (resume) r_state <= S_INST_ADDR;
                default:      r_state <= S_INST_ADDR;
            endcase
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        halt   = 1'b0;
        inc_pc = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        case (r_state)
            S_INST_ADDR:  sel = 1'b1;
            S_INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            S_INST_LOAD, S_IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            S_OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = w_hlt;
            end
            S_OP_FETCH:   rd = w_alu;
            S_ALU_OP: begin
                rd     = w_alu;
                inc_pc = w_skz & zero;
                ld_pc  = w_jmp;
                data_e = w_sto;
            end
            S_STORE: begin
                rd     = w_alu;
                ld_ac  = w_alu;
                ld_pc  = w_jmp;
                wr     = w_sto;
                data_e = w_sto;
            end
            S_HALTED:     halt = 1'b1;
            default:      ;
        endcase
    end

    // The flag is already visible in the OP_ADDR cycle that decodes the bad opcode.
    assign illegal   = r_illegal | ((r_state == S_OP_ADDR) & w_hi_nz);
    assign phase     = r_state;
    assign instr_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_controller
// Brief    : Scoreboard bench for seq_controller (OPW=4, CNT_W=2) with
//            directed per-cycle vectors and hand-computed expectations.
// Revision : 1.0
// ============================================================================
module tb_seq_controller;

    typedef struct packed {
        logic [3:0] ph;
        logic [8:0] ct;   // {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e}
        logic       il;
        logic [1:0] cn;
    } exp_t;

    localparam logic [8:0] c_p0   = 9'b100000000;
    localparam logic [8:0] c_p1   = 9'b110000000;
    localparam logic [8:0] c_p2   = 9'b111000000;
    localparam logic [8:0] c_oa   = 9'b000010000;
    localparam logic [8:0] c_oah  = 9'b000110000;
    localparam logic [8:0] c_rd   = 9'b010000000;
    localparam logic [8:0] c_zz   = 9'b000000000;
    localparam logic [8:0] c_ldac = 9'b010001000;
    localparam logic [8:0] c_pc   = 9'b000000100;
    localparam logic [8:0] c_de   = 9'b000000001;
    localparam logic [8:0] c_wr   = 9'b000000011;
    localparam logic [8:0] c_hl   = 9'b000100000;

    localparam logic [3:0] c_hlt  = 4'b0000;
    localparam logic [3:0] c_skz  = 4'b0001;
    localparam logic [3:0] c_add  = 4'b0010;
    localparam logic [3:0] c_sto  = 4'b0110;
    localparam logic [3:0] c_jmp  = 4'b0111;
    localparam logic [3:0] c_bad  = 4'b1010;
    localparam logic [3:0] c_bad2 = 4'b1000;

    logic       clk;
    logic       rst;
    logic       zero;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       resume;
    logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
    logic [3:0] phase;
    logic       illegal;
    logic [1:0] instr_cnt;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    seq_controller #(.OPW(4), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .zero      (zero),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .resume    (resume),
        .sel       (sel),
        .rd        (rd),
        .ld_ir     (ld_ir),
        .halt      (halt),
        .inc_pc    (inc_pc),
        .ld_ac     (ld_ac),
        .ld_pc     (ld_pc),
        .wr        (wr),
        .data_e    (data_e),
        .phase     (phase),
        .illegal   (illegal),
        .instr_cnt (instr_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Inputs set in a row hold for that whole cycle; the row's expectation is what
    // the DUT must present during the same cycle.
    task automatic cyc(input logic r, input logic z, input logic [3:0] op,
                       input logic mr, input logic rs, input logic [3:0] ph,
                       input logic [8:0] ct, input logic il, input logic [1:0] cn);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; zero = z; opcode = op; mem_ready = mr; resume = rs;
        e.ph = ph; e.ct = ct; e.il = il; e.cn = cn;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        exp_t a;
        int   idx;
        idx = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.ph = phase;
                a.ct = {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e};
                a.il = illegal;
                a.cn = instr_cnt;
                n_chk++;
                if (a === e) n_pass++;
                else $display("FAIL cyc%0d: got ph=%0d ctl=%b ill=%b cnt=%0d, want ph=%0d ctl=%b ill=%b cnt=%0d",
                              idx, a.ph, a.ct, a.il, a.cn, e.ph, e.ct, e.il, e.cn);
                idx++;
            end
        end
    end

    initial begin : stimulus
        rst = 1'b0; zero = 1'b0; opcode = c_add; mem_ready = 1'b1; resume = 1'b0;
        @(posedge clk);
        #1;
        //  r  z  op     mr rs  ph  ctrl    il cn
        cyc(0, 0, c_add, 1, 0, 0, c_p0,   0, 0);
        // ADD with mem_ready tied high
        cyc(1, 0, c_add, 1, 0, 0, c_p0,   0, 0);
        cyc(1, 0, c_add, 1, 0, 1, c_p1,   0, 0);
        cyc(1, 0, c_add, 1, 0, 2, c_p2,   0, 0);
        cyc(1, 0, c_add, 1, 0, 3, c_p2,   0, 0);
        cyc(1, 0, c_add, 1, 0, 4, c_oa,   0, 0);
        cyc(1, 0, c_add, 1, 0, 5, c_rd,   0, 0);
        cyc(1, 0, c_add, 1, 0, 6, c_rd,   0, 0);
        cyc(1, 0, c_add, 1, 0, 7, c_ldac, 0, 0);
        // ADD with instruction-fetch and operand-fetch stalls
        cyc(1, 0, c_add, 0, 0, 0, c_p0,   0, 1);
        cyc(1, 0, c_add, 0, 0, 1, c_p1,   0, 1);
        cyc(1, 0, c_add, 0, 0, 1, c_p1,   0, 1);
        cyc(1, 0, c_add, 0, 0, 1, c_p1,   0, 1);
        cyc(1, 0, c_add, 1, 0, 1, c_p1,   0, 1);
        cyc(1, 0, c_add, 1, 0, 2, c_p2,   0, 1);
        cyc(1, 0, c_add, 1, 0, 3, c_p2,   0, 1);
        cyc(1, 0, c_add, 1, 0, 4, c_oa,   0, 1);
        cyc(1, 0, c_add, 0, 0, 5, c_rd,   0, 1);
        cyc(1, 0, c_add, 1, 0, 5, c_rd,   0, 1);
        cyc(1, 0, c_add, 1, 0, 6, c_rd,   0, 1);
        cyc(1, 0, c_add, 1, 0, 7, c_ldac, 0, 1);
        // SKZ with zero=1, non-aluop ignores mem_ready in OP_FETCH/STORE
        cyc(1, 0, c_skz, 1, 0, 0, c_p0,   0, 2);
        cyc(1, 0, c_skz, 1, 0, 1, c_p1,   0, 2);
        cyc(1, 0, c_skz, 1, 0, 2, c_p2,   0, 2);
        cyc(1, 0, c_skz, 1, 0, 3, c_p2,   0, 2);
        cyc(1, 0, c_skz, 1, 0, 4, c_oa,   0, 2);
        cyc(1, 1, c_skz, 0, 0, 5, c_zz,   0, 2);
        cyc(1, 1, c_skz, 0, 0, 6, c_oa,   0, 2);
        cyc(1, 1, c_skz, 0, 0, 7, c_zz,   0, 2);
        // SKZ with zero=0 in ALU_OP; counter wraps 3 -> 0 afterwards
        cyc(1, 0, c_skz, 1, 0, 0, c_p0,   0, 3);
        cyc(1, 0, c_skz, 1, 0, 1, c_p1,   0, 3);
        cyc(1, 0, c_skz, 1, 0, 2, c_p2,   0, 3);
        cyc(1, 1, c_skz, 1, 0, 3, c_p2,   0, 3);
        cyc(1, 1, c_skz, 1, 0, 4, c_oa,   0, 3);
        cyc(1, 0, c_skz, 1, 0, 5, c_zz,   0, 3);
        cyc(1, 0, c_skz, 1, 0, 6, c_zz,   0, 3);
        cyc(1, 0, c_skz, 1, 0, 7, c_zz,   0, 3);
        // JMP
        cyc(1, 0, c_jmp, 1, 0, 0, c_p0,   0, 0);
        cyc(1, 0, c_jmp, 1, 0, 1, c_p1,   0, 0);
        cyc(1, 0, c_jmp, 1, 0, 2, c_p2,   0, 0);
        cyc(1, 0, c_jmp, 1, 0, 3, c_p2,   0, 0);
        cyc(1, 0, c_jmp, 1, 0, 4, c_oa,   0, 0);
        cyc(1, 0, c_jmp, 1, 0, 5, c_zz,   0, 0);
        cyc(1, 0, c_jmp, 1, 0, 6, c_pc,   0, 0);
        cyc(1, 0, c_jmp, 1, 0, 7, c_pc,   0, 0);
        // STO with a two-cycle store stall
        cyc(1, 0, c_sto, 1, 0, 0, c_p0,   0, 1);
        cyc(1, 0, c_sto, 1, 0, 1, c_p1,   0, 1);
        cyc(1, 0, c_sto, 1, 0, 2, c_p2,   0, 1);
        cyc(1, 0, c_sto, 1, 0, 3, c_p2,   0, 1);
        cyc(1, 0, c_sto, 1, 0, 4, c_oa,   0, 1);
        cyc(1, 0, c_sto, 1, 0, 5, c_zz,   0, 1);
        cyc(1, 0, c_sto, 1, 0, 6, c_de,   0, 1);
        cyc(1, 0, c_sto, 0, 0, 7, c_wr,   0, 1);
        cyc(1, 0, c_sto, 0, 0, 7, c_wr,   0, 1);
        cyc(1, 0, c_sto, 1, 0, 7, c_wr,   0, 1);
        // HLT: resume outside HALTED ignored, HALTED held, resume restarts
        cyc(1, 0, c_hlt, 1, 0, 0, c_p0,   0, 2);
        cyc(1, 0, c_hlt, 1, 0, 1, c_p1,   0, 2);
        cyc(1, 0, c_hlt, 1, 0, 2, c_p2,   0, 2);
        cyc(1, 0, c_hlt, 1, 1, 3, c_p2,   0, 2);
        cyc(1, 0, c_hlt, 1, 0, 4, c_oah,  0, 2);
        cyc(1, 0, c_hlt, 0, 0, 8, c_hl,   0, 2);
        cyc(1, 0, c_hlt, 1, 0, 8, c_hl,   0, 2);
        cyc(1, 0, c_hlt, 1, 1, 8, c_hl,   0, 2);
        // Illegal opcode: sticky flag survives resume, cleared by reset
        cyc(1, 0, c_bad, 1, 0, 0, c_p0,   0, 2);
        cyc(1, 0, c_bad, 1, 0, 1, c_p1,   0, 2);
        cyc(1, 0, c_bad, 1, 0, 2, c_p2,   0, 2);
        cyc(1, 0, c_bad, 1, 0, 3, c_p2,   0, 2);
        cyc(1, 0, c_bad, 1, 0, 4, c_oah,  1, 2);
        cyc(1, 0, c_bad, 1, 0, 8, c_hl,   1, 2);
        cyc(1, 0, c_bad, 1, 1, 8, c_hl,   1, 2);
        cyc(1, 0, c_add, 1, 0, 0, c_p0,   1, 2);
        cyc(0, 0, c_add, 1, 0, 1, c_p1,   1, 2);
        cyc(0, 0, c_add, 1, 0, 0, c_p0,   0, 0);
        // Reset during a STORE stall
        cyc(1, 0, c_sto, 1, 0, 0, c_p0,   0, 0);
        cyc(1, 0, c_sto, 1, 0, 1, c_p1,   0, 0);
        cyc(1, 0, c_sto, 1, 0, 2, c_p2,   0, 0);
        cyc(1, 0, c_sto, 1, 0, 3, c_p2,   0, 0);
        cyc(1, 0, c_sto, 1, 0, 4, c_oa,   0, 0);
        cyc(1, 0, c_sto, 1, 0, 5, c_zz,   0, 0);
        cyc(1, 0, c_sto, 1, 0, 6, c_de,   0, 0);
        cyc(1, 0, c_sto, 0, 0, 7, c_wr,   0, 0);
        cyc(0, 0, c_sto, 0, 0, 7, c_wr,   0, 0);
        // Reset beats resume while HALTED on an illegal opcode
        cyc(1, 0, c_bad2, 1, 0, 0, c_p0,  0, 0);
        cyc(1, 0, c_bad2, 1, 0, 1, c_p1,  0, 0);
        cyc(1, 0, c_bad2, 1, 0, 2, c_p2,  0, 0);
        cyc(1, 0, c_bad2, 1, 0, 3, c_p2,  0, 0);
        cyc(1, 0, c_bad2, 1, 0, 4, c_oah, 1, 0);
        cyc(0, 0, c_bad2, 1, 1, 8, c_hl,  1, 0);
        cyc(1, 0, c_bad2, 1, 0, 0, c_p0,  0, 0);
        cyc(1, 0, c_bad2, 1, 0, 1, c_p1,  0, 0);

        repeat (3) @(posedge clk);
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 SHALL have parameter OPW, default 3, meaning opcode width (legal: OPW >= 3).
REQ-002 SHALL have parameter CNT_W, default 16, meaning retired-instruction counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports zero  input  1  accumulator-zero flag; opcode  input  OPW  instruction opcode from IR.
REQ-006 SHALL have ports mem_ready  input  1  memory access complete; resume  input  1  single-cycle restart request from HALTED.
REQ-007 SHALL have outputs sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, each 1 bit, meaning datapath controls.
REQ-008 SHALL have outputs phase  output  4  current state code; illegal  output  1  sticky illegal-opcode flag; instr_cnt  output  CNT_W  retired instructions.

Function
REQ-009 SHALL decode opcode[2:0]: 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP.
REQ-010 SHALL treat any opcode with opcode[OPW-1:3] nonzero as HLT and set illegal in the OP_ADDR cycle.
REQ-011 SHALL define aluop = ADD|AND|XOR|LDA.
REQ-012 SHALL implement states (phase code): INST_ADDR 0, INST_FETCH 1, INST_LOAD 2, IDLE 3, OP_ADDR 4, OP_FETCH 5, ALU_OP 6, STORE 7, HALTED 8.
REQ-013 SHALL sequence 0->1->2->3->4->5->6->7->0, one state per cycle unless stalled or halted.
REQ-014 SHALL stall in INST_FETCH until mem_ready=1; advance on the edge where mem_ready=1.
REQ-015 SHALL stall in OP_FETCH when aluop and mem_ready=0; non-aluop opcodes do not wait.
REQ-016 SHALL stall in STORE when opcode=STO and mem_ready=0; other opcodes do not wait.
REQ-017 SHALL, in OP_ADDR with effective HLT, go to HALTED instead of OP_FETCH.
REQ-018 SHALL stay in HALTED until resume=1, then go to INST_ADDR.
REQ-019 SHALL drive outputs combinationally from state, opcode, zero (Moore plus opcode decode); unlisted outputs 0:
- INST_ADDR: sel
- INST_FETCH: sel, rd
- INST_LOAD, IDLE: sel, rd, ld_ir
- OP_ADDR: inc_pc; halt=HLT
- OP_FETCH: rd=aluop
- ALU_OP: rd=aluop; inc_pc=SKZ&zero; ld_pc=JMP; data_e=STO
- STORE: rd=aluop; ld_ac=aluop; ld_pc=JMP; wr=STO; data_e=STO
- HALTED: halt
REQ-020 SHALL hold all outputs constant for every cycle of a stall.
REQ-021 SHALL increment instr_cnt by 1 on each STORE->INST_ADDR transition, wrapping modulo 2^CNT_W.
REQ-022 SHALL NOT count halted instructions; HALTED entry does not increment instr_cnt.
REQ-023 SHALL ignore resume outside HALTED, and mem_ready outside stall-capable states.
REQ-024 SHALL sample opcode and zero only in the state consuming them; changes elsewhere do not alter state flow.

Reset
REQ-025 SHALL, on rising clk with rst=0, enter INST_ADDR, clear illegal and instr_cnt, regardless of current state, including stall or HALTED.
REQ-026 SHALL give reset priority over resume and mem_ready in the same cycle.
REQ-027 SHALL present, in the first cycle after reset, phase=0, sel=1, all other controls 0, illegal=0, instr_cnt=0.

Verification
REQ-028 SHALL cover: ADD, mem_ready tied 1 -> phases 0..7 in 8 cycles; ld_ac=1 in phase 7; instr_cnt 0->1.
REQ-029 SHALL cover: INST_FETCH with mem_ready=0 for 3 cycles -> phase=1, sel=rd=1 held 4 cycles total, then phase 2.
REQ-030 SHALL cover: SKZ with zero=1 -> inc_pc=1 in phase 4 and phase 6; zero=0 -> inc_pc only in phase 4.
REQ-031 SHALL cover: opcode=000 -> phase 4 halt=1, then phase 8 halt=1 held; resume pulse -> phase 0 next cycle; instr_cnt unchanged.
REQ-032 SHALL cover: OPW=4, opcode=1010 -> illegal=1, HALTED; illegal stays 1 after resume; rst=0 clears it.
REQ-033 SHALL cover: CNT_W=2, four STO with mem_ready=1 -> wr=1, data_e=1 in phase 7; instr_cnt 3->0 wrap; rst=0 mid-STORE stall -> phase 0 next cycle.
